seq_alu: RTL and testbench

Parametrised, registered successor to the 64-bit combinational ALU. It adds a WIDTH parameter, a multi-cycle iterative multiply, valid/ready handshakes on both sides, and ARM-style conditional flag update. It sits between the register-read stage and writeback of the pipelined CPU. Flags persist in the block and feed the conditional-branch unit.

---
 rtl/seq_alu.sv | 147 ++++++++++++++
 tb/tb_seq_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes, iterative shift-add multiply and
// conditionally updated NZVC flags that persist for the branch unit.
module seq_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [2*WIDTH-1:0]   r_acc, r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [CW-1:0]        r_cnt;
    logic                 r_setf;
    logic [WIDTH-1:0]     r_result;
    logic                 r_n, r_z, r_v, r_c;

    logic                 w_accept, w_mul_last;
    logic [WIDTH:0]       w_add, w_sub;
    logic [WIDTH-1:0]     w_res;
    logic                 w_v, w_c;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign in_ready   = reset_n && (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(WIDTH));

    assign result    = r_result;
    assign negative  = r_n;
    assign zero      = r_z;
    assign overflow  = r_v;
    assign carry_out = r_c;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (cntrl == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:   if (w_mul_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Subtract is A + ~B + 1 so carry_out reads as "no borrow".
    assign w_add = {1'b0, A} + {1'b0, B};
    assign w_sub = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (cntrl)
            OP_PASS: w_res = B;
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_XOR:  w_res = A ^ B;
            default: w_res = '0;
        endcase
    end

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_setf   <= 1'b0;
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
        end else if (w_accept) begin
            r_setf <= set_flags;
            if (cntrl == OP_MUL) begin
                r_acc    <= '0;
                r_mcand  <= {{WIDTH{1'b0}}, A};
                r_mplier <= B;
                r_cnt    <= '0;
            end else begin
                r_result <= w_res;
                if (set_flags) begin
                    r_n <= w_res[WIDTH-1];
                    r_z <= (w_res == '0);
                    r_v <= w_v;
                    r_c <= w_c;
                end
            end
        end else if (w_mul_last) begin
            // Accumulator holds the full product; only the low half is returned.
            r_result <= r_acc[WIDTH-1:0];
            if (r_setf) begin
                r_n <= r_acc[WIDTH-1];
                r_z <= (r_acc[WIDTH-1:0] == '0);
                r_v <= 1'b0;
                r_c <= (r_acc[2*WIDTH-1:WIDTH] != '0);
            end
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_cnt    <= r_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 64-bit instance for ALU/flag/backpressure/reset
// cases and an 8-bit instance for multiply latency and products.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        reset_n;

    logic        iv64, ir64, ov64, or64, sf64;
    logic [63:0] a64, b64, res64;
    logic [2:0]  op64;
    logic        n64, z64, v64, c64;

    logic        iv8, ir8, ov8, or8, sf8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  op8;
    logic        n8, z8, v8, c8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(64)) u64 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv64), .in_ready(ir64),
        .A(a64), .B(b64), .cntrl(op64), .set_flags(sf64),
        .out_valid(ov64), .out_ready(or64), .result(res64),
        .negative(n64), .zero(z64), .overflow(v64), .carry_out(c64)
    );

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .cntrl(op8), .set_flags(sf8),
        .out_valid(ov8), .out_ready(or8), .result(res8),
        .negative(n8), .zero(z8), .overflow(v8), .carry_out(c8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] r,
                         input logic n, input logic z, input logic v, input logic c);
        chk({tag, "_ov"}, {63'd0, ov64}, 64'd1);
        chk({tag, "_res"}, res64, r);
        chk({tag, "_nzvc"}, {60'd0, n64, z64, v64, c64}, {60'd0, n, z, v, c});
    endtask

    task automatic issue64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic sf);
        op64 = op; a64 = a; b64 = b; sf64 = sf; iv64 = 1'b1;
        tick();
        iv64 = 1'b0;
    endtask

    task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic c, input logic n);
        int ec;
        op8 = 3'b001; a8 = a; b8 = b; sf8 = 1'b1; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        a8 = ~a; b8 = ~b;
        ec = 0;
        do begin
            tick();
            ec++;
        end while (!ov8 && ec < 40);
        chk({tag, "_lat"}, 64'(ec), 64'd9);
        chk({tag, "_res"}, {56'd0, res8}, {56'd0, r});
        chk({tag, "_nzvc"}, {60'd0, n8, z8, v8, c8}, {60'd0, n, (r == 8'd0), 1'b0, c});
        tick();
        chk({tag, "_idle"}, {62'd0, ov8, ir8}, 64'd1);
    endtask

    initial begin
        int pulses;
        reset_n = 1'b0;
        iv64 = 0; a64 = '0; b64 = '0; op64 = '0; sf64 = 0; or64 = 1;
        iv8 = 0;  a8 = '0;  b8 = '0;  op8 = '0;  sf8 = 0;  or8 = 1;
        tick();
        tick();
        chk("rst_in_ready_low", {63'd0, ir64}, 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, ir64}, 64'd1);
        chk("rst_ov", {62'd0, ov64, ov8}, 64'd0);
        chk("rst_res", res64, 64'd0);
        chk("rst_flags", {60'd0, n64, z64, v64, c64}, 64'd0);

        // Signed overflow on ADD, result in the cycle after accept
        issue64(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        chk64("add_ovf", 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 1, 0);
        chk("add_busy", {63'd0, ir64}, 64'd0);
        tick();
        chk("add_back_idle", {62'd0, ov64, ir64}, 64'd1);

        issue64(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        chk64("add_carry", 64'd0, 0, 1, 0, 1);
        tick();

        issue64(3'b011, 64'd1, 64'd1, 1'b1);
        chk64("sub_eq", 64'd0, 0, 1, 0, 1);
        tick();

        issue64(3'b011, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        chk64("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 1);
        tick();

        issue64(3'b011, 64'd1, 64'd1, 1'b1);
        tick();
        // Flags from the SUB must survive an op with set_flags=0
        issue64(3'b110, 64'h1010_1010_1010_1010, 64'h1010_1010_1010_1010, 1'b0);
        chk64("xor_hold", 64'd0, 0, 1, 0, 1);
        tick();

        issue64(3'b100, 64'hF0F0, 64'hFF00, 1'b1);
        chk64("and", 64'hF000, 0, 0, 0, 0);
        tick();
        issue64(3'b000, 64'd3, 64'h8000_0000_0000_0001, 1'b1);
        chk64("pass_b", 64'h8000_0000_0000_0001, 1, 0, 0, 0);
        tick();
        issue64(3'b111, 64'd3, 64'd5, 1'b1);
        chk64("reserved", 64'd0, 0, 1, 0, 0);
        tick();

        // Backpressure: hold DONE while inputs churn
        or64 = 1'b0;
        issue64(3'b010, 64'd5, 64'd3, 1'b1);
        chk64("bp_first", 64'd8, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            a64 = 64'(i * 7 + 1); b64 = 64'hFFFF_FFFF_FFFF_FFF0; op64 = 3'b011;
            iv64 = i[0]; sf64 = 1'b1;
            tick();
            chk64("bp_hold", 64'd8, 0, 0, 0, 0);
            chk("bp_in_ready", {63'd0, ir64}, 64'd0);
        end
        iv64 = 1'b0;
        or64 = 1'b1;
        tick();
        chk("bp_release", {62'd0, ov64, ir64}, 64'd1);
        chk("bp_res_kept", res64, 64'd8);

        mul8("mul200x3", 8'd200, 8'd3, 8'h58, 1'b1, 1'b0);
        mul8("mul7x6", 8'd7, 8'd6, 8'd42, 1'b0, 1'b0);
        mul8("mulffxff", 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
        mul8("mul0", 8'd0, 8'hAB, 8'd0, 1'b0, 1'b0);

        // Abort a 64-bit multiply at iteration 10
        issue64(3'b001, 64'h1234_5678, 64'hFFFF_FFFF, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ov64) pulses++;
        end
        reset_n = 1'b0;
        tick();
        chk("mrst_in_ready", {63'd0, ir64}, 64'd0);
        reset_n = 1'b1;
        #1;
        chk("mrst_res", res64, 64'd0);
        chk("mrst_flags", {60'd0, n64, z64, v64, c64}, 64'd0);
        chk("mrst_in_ready_rel", {63'd0, ir64}, 64'd1);
        for (int i = 0; i < 80; i++) begin
            tick();
            if (ov64) pulses++;
        end
        chk("mrst_no_pulse", 64'(pulses), 64'd0);
        issue64(3'b010, 64'd2, 64'd3, 1'b1);
        chk64("mrst_add", 64'd5, 0, 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
